// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// stage bit positions, default timing constants and a stage-mask helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_WAIT  = 2'd1,
    MEM_WAIT  = 2'd2,
    EXC_FLUSH = 2'd3
  } state_t;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CW          = 8;

  // Contiguous run of stage bits, first..last inclusive
  function automatic logic [4:0] stages(input int first, input int last);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++)
      if (i >= first && i <= last) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush/pulse outputs back to the
// stage register banks.
interface pipeline_hazard_ctrl_if;
  logic [4:0] rsD, rtD, rtE;
  logic       memtoregE, pcsrcD, divE, memreqM, dmem_ready, exceptionM;
  logic [4:0] stall, flush;
  logic       pc_redirect, bus_error, div_done;

  modport master (
    output rsD, rtD, rtE, memtoregE, pcsrcD, divE, memreqM, dmem_ready, exceptionM,
    input  stall, flush, pc_redirect, bus_error, div_done
  );

  modport slave (
    input  rsD, rtD, rtE, memtoregE, pcsrcD, divE, memreqM, dmem_ready, exceptionM,
    output stall, flush, pc_redirect, bus_error, div_done
  );
endinterface

// File: rtl/ctrl_cycle_counter.sv
// Saturating up-counter with clear > load > increment priority.
module ctrl_cycle_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          load,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  q <= '0;
    else if (clr)             q <= '0;
    else if (load)            q <= din;
    else if (inc && q != '1)  q <= q + CW'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational load-use and
// branch handling plus an FSM for divide, memory wait and exception flush.
//
// state     | meaning
// IDLE      | no multi-cycle hazard; load-use / branch resolved combinationally
// DIV_WAIT  | divide occupying E; F,D,E held, bubble into M
// MEM_WAIT  | data memory wait; F..M held, bubble into W
// EXC_FLUSH | one-cycle flush of D..W with PC redirect to exception vector
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CW          = DEF_CW
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] MEM_LIM  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, div_cnt, cnt_din;
  logic          cnt_clr, cnt_inc, cnt_load, dcnt_clr, dcnt_load;
  logic [4:0]    stall_c, flush_c;
  logic          pcr_c, be_c, dd_c;
  logic          load_use, mem_stall, timeout;

  assign load_use  = hz.memtoregE && (hz.rtE != '0) &&
                     ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
  assign mem_stall = hz.memreqM && !hz.dmem_ready;
  assign timeout   = (state == MEM_WAIT) && !hz.dmem_ready && (cnt == MEM_LIM);

  ctrl_cycle_counter #(.CW(CW)) u_wait_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_inc), .load(cnt_load),
    .din(cnt_din), .q(cnt)
  );

  // Holds divide progress while a memory wait pre-empts it; nonzero means a divide is pending
  ctrl_cycle_counter #(.CW(CW)) u_div_cnt (
    .clk(clk), .rst(rst), .clr(dcnt_clr), .inc(1'b0), .load(dcnt_load),
    .din(cnt), .q(div_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall_c   = '0;
    flush_c   = '0;
    pcr_c     = 1'b0;
    be_c      = 1'b0;
    dd_c      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_load  = 1'b0;
    cnt_din   = ONE;
    dcnt_clr  = 1'b0;
    dcnt_load = 1'b0;
    case (state)
      EXC_FLUSH: begin
        flush_c  = stages(STG_D, STG_W);
        pcr_c    = 1'b1;
        cnt_clr  = 1'b1;
        dcnt_clr = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        if (hz.exceptionM || timeout) begin
          stall_c  = stages(STG_F, STG_E);
          flush_c  = stages(STG_M, STG_W);
          be_c     = timeout;
          cnt_clr  = 1'b1;
          dcnt_clr = 1'b1;
          state_nx = EXC_FLUSH;
        end else if (state == MEM_WAIT) begin
          if (hz.dmem_ready) begin
            cnt_load = 1'b1;
            cnt_din  = div_cnt;
            dcnt_clr = 1'b1;
            if (div_cnt != '0) begin
              // divide still sits in E: keep holding it through the hand-back
              stall_c  = stages(STG_F, STG_E);
              flush_c  = stages(STG_M, STG_M);
              state_nx = DIV_WAIT;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            stall_c = stages(STG_F, STG_M);
            flush_c = stages(STG_W, STG_W);
            cnt_inc = 1'b1;
          end
        end else if (mem_stall) begin
          stall_c   = stages(STG_F, STG_M);
          flush_c   = stages(STG_W, STG_W);
          cnt_load  = 1'b1;
          dcnt_load = (state == DIV_WAIT);
          state_nx  = MEM_WAIT;
        end else if (state == DIV_WAIT || hz.divE) begin
          if (state == DIV_WAIT && cnt == DIV_LAST) begin
            dd_c     = 1'b1;
            cnt_clr  = 1'b1;
            state_nx = IDLE;
          end else begin
            stall_c  = stages(STG_F, STG_E);
            flush_c  = stages(STG_M, STG_M);
            cnt_load = (state == IDLE);
            cnt_inc  = (state == DIV_WAIT);
            state_nx = DIV_WAIT;
          end
        end else if (load_use) begin
          stall_c = stages(STG_F, STG_D);
          flush_c = stages(STG_E, STG_E);
        end else if (hz.pcsrcD) begin
          flush_c = stages(STG_D, STG_D);
        end
      end
    endcase
  end

  assign hz.stall       = rst ? '0 : stall_c;
  assign hz.flush       = rst ? '0 : flush_c;
  assign hz.pc_redirect = !rst && pcr_c;
  assign hz.bus_error   = !rst && be_c;
  assign hz.div_done    = !rst && dd_c;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; dut_b uses a short
// memory timeout so the bus-error path is reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if ha ();
  pipeline_hazard_ctrl_if hb ();

  assign hb.rsD        = ha.rsD;
  assign hb.rtD        = ha.rtD;
  assign hb.rtE        = ha.rtE;
  assign hb.memtoregE  = ha.memtoregE;
  assign hb.pcsrcD     = ha.pcsrcD;
  assign hb.divE       = ha.divE;
  assign hb.memreqM    = ha.memreqM;
  assign hb.dmem_ready = ha.dmem_ready;
  assign hb.exceptionM = ha.exceptionM;

  pipeline_hazard_ctrl #(.DIV_CYCLES(4), .MEM_TIMEOUT(8), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .hz(ha.slave)
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(4), .MEM_TIMEOUT(3), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .hz(hb.slave)
  );

  typedef struct {
    string      tag;
    bit         sel;
    logic [12:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  tests = 0;
  int  fails = 0;

  function automatic logic [12:0] obs(input bit sel);
    if (sel) return {hb.stall, hb.flush, hb.pc_redirect, hb.bus_error, hb.div_done};
    return {ha.stall, ha.flush, ha.pc_redirect, ha.bus_error, ha.div_done};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rte,
                       input logic m2r, input logic pcs, input logic div,
                       input logic mreq, input logic rdy, input logic exc);
    ha.rsD = rs; ha.rtD = rt; ha.rtE = rte;
    ha.memtoregE = m2r; ha.pcsrcD = pcs; ha.divE = div;
    ha.memreqM = mreq; ha.dmem_ready = rdy; ha.exceptionM = exc;
  endtask

  task automatic expect_out(input string tag, input bit sel, input logic [4:0] st,
                            input logic [4:0] fl, input logic pcr, input logic be,
                            input logic dd);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = {st, fl, pcr, be, dd};
    sbq.push_back(e);
  endtask

  task automatic compare_all();
    sb_t         e;
    logic [12:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      tests++;
      assert (o === e.exp)
      else begin
        fails++;
        $error("FAIL %s observed={stall,flush,pcr,be,dd}=%b required=%b", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic cyc(input string tag, input bit sel, input logic [4:0] st,
                     input logic [4:0] fl, input logic pcr, input logic be, input logic dd);
    expect_out(tag, sel, st, fl, pcr, be, dd);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'd1, 5'd1, 5'd1, 1, 1, 1, 1, 0, 1);
    #1;
    expect_out("rst_a", 0, 5'b0, 5'b0, 0, 0, 0);
    expect_out("rst_b", 1, 5'b0, 5'b0, 0, 0, 0);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
  endtask

  // Stage-level invariants on both instances
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      assert (((ha.stall & ha.flush) == 5'b0) && (ha.flush[0] == 1'b0) &&
              ((hb.stall & hb.flush) == 5'b0) && (hb.flush[0] == 1'b0))
      else begin
        fails++;
        $error("FAIL overlap observed a=%b/%b b=%b/%b required no stall&flush overlap, flush[0]=0",
               ha.stall, ha.flush, hb.stall, hb.flush);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // load-use and branch
    drive(5'd1, 5'd2, 5'd1, 1, 0, 0, 0, 0, 0); cyc("lu_rs",    0, 5'b00011, 5'b00100, 0, 0, 0);
    drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0); cyc("lu_clear", 0, 5'b00000, 5'b00000, 0, 0, 0);
    drive(5'd3, 5'd5, 5'd5, 1, 0, 0, 0, 0, 0); cyc("lu_rt",    0, 5'b00011, 5'b00100, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0); cyc("lu_r0",    0, 5'b00000, 5'b00000, 0, 0, 0);
    drive(5'd7, 5'd2, 5'd7, 0, 0, 0, 0, 0, 0); cyc("nonload",  0, 5'b00000, 5'b00000, 0, 0, 0);
    drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 0); cyc("br",       0, 5'b00000, 5'b00010, 0, 0, 0);
    drive(5'd4, 5'd2, 5'd4, 1, 1, 0, 0, 0, 0); cyc("br_lu",    0, 5'b00011, 5'b00100, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0); cyc("mem_zw",   0, 5'b00000, 5'b00000, 0, 0, 0);

    // divide, DIV_CYCLES=4
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("div_busy", 0, 5'b00111, 5'b01000, 0, 0, 0);
    cyc("div_done", 0, 5'b00000, 5'b00000, 0, 0, 1);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0); cyc("div_idle", 0, 5'b00000, 5'b00000, 0, 0, 0);

    // memory wait, released after 5 stalled cycles
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc("mem_wait", 0, 5'b01111, 5'b10000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0); cyc("mem_rel",  0, 5'b00000, 5'b00000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0); cyc("mem_idle", 0, 5'b00000, 5'b00000, 0, 0, 0);

    // timeout on dut_b (MEM_TIMEOUT=3)
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("to_wait", 1, 5'b01111, 5'b10000, 0, 0, 0);
    cyc("to_buserr", 1, 5'b00111, 5'b11000, 0, 1, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    cyc("to_redirect", 1, 5'b00000, 5'b11110, 1, 0, 0);
    cyc("to_idle",     1, 5'b00000, 5'b00000, 0, 0, 0);

    // async reset during divide
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    cyc("rd_c1", 0, 5'b00111, 5'b01000, 0, 0, 0);
    expect_out("rd_c2", 0, 5'b00111, 5'b01000, 0, 0, 0);
    @(negedge clk);
    compare_all();
    #2 rst = 1'b1;
    #1 expect_out("rd_rst", 0, 5'b00000, 5'b00000, 0, 0, 0);
    compare_all();
    @(posedge clk);
    #1;
    expect_out("rd_hold", 0, 5'b00000, 5'b00000, 0, 0, 0);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("rd_after", 0, 5'b00000, 5'b00000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("rd_div", 0, 5'b00111, 5'b01000, 0, 0, 0);
    cyc("rd_done", 0, 5'b00000, 5'b00000, 0, 0, 1);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0); cyc("rd_idle", 0, 5'b00000, 5'b00000, 0, 0, 0);

    // exception mid-divide
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("ex_div", 0, 5'b00111, 5'b01000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1); cyc("ex_hit",   0, 5'b00111, 5'b11000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0); cyc("ex_flush", 0, 5'b00000, 5'b11110, 1, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0); cyc("ex_idle",  0, 5'b00000, 5'b00000, 0, 0, 0);

    // memory wait pre-empting a divide, divide resumes at saved count
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("md_div", 0, 5'b00111, 5'b01000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("md_mem", 0, 5'b01111, 5'b10000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0); cyc("md_resume", 0, 5'b00111, 5'b01000, 0, 0, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0); cyc("md_div2",   0, 5'b00111, 5'b01000, 0, 0, 0);
    cyc("md_done", 0, 5'b00000, 5'b00000, 0, 0, 1);

    // back-to-back divide re-enters right after div_done
    for (int i = 0; i < 3; i++) cyc("b2b_busy", 0, 5'b00111, 5'b01000, 0, 0, 0);
    cyc("b2b_done",  0, 5'b00000, 5'b00000, 0, 0, 1);
    cyc("b2b_again", 0, 5'b00111, 5'b01000, 0, 0, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
